// File: rtl/seq_mult_pkg.sv
// Shared definitions for seq_mult and its downstream collector: default width,
// collector state encoding and the slice-count helper.
package seq_mult_pkg;

    localparam int SM_W  = 16;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } collector_state_e;

    // Number of P-bit slices that make up a 2*bit_size-bit product (rounded up).
    function automatic logic [CNT_W-1:0] slice_count(input logic [3:0] bit_size, input int p_w);
        int n;
        n = (2 * int'(bit_size) + p_w - 1) / p_w;
        return n[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/seq_mult_collector.sv
// Reassembles the LSB-first product slices of seq_mult into a right-aligned,
// optionally sign-extended product and offers it on a valid/ready port.
module seq_mult_collector
    import seq_mult_pkg::*;
#(
    parameter int P = 2,
    parameter int W = SM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       bitSize,
    input  logic             signed_mode,
    input  logic [P-1:0]     p,
    input  logic             newOut,
    input  logic             done,
    output logic [2*W-1:0]   prod_o,
    output logic             prod_valid,
    input  logic             prod_ready,
    output logic             busy,
    output logic             short_err,
    output logic             ovf_err
);

    collector_state_e   state_q, state_d;
    logic [2*W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [3:0]         bsz_q, bsz_d;
    logic               sgn_q, sgn_d;
    logic [2*W-1:0]     prod_q, prod_d;
    logic               valid_q, valid_d;
    logic               short_q, short_d;
    logic               ovf_q, ovf_d;
    logic               open_req;
    logic [CNT_W-1:0]   n_start;

    assign n_start = slice_count(bitSize, P);

    // Slices arrive at the top of acc, so cnt slices occupy acc[2W-1 -: cnt*P].
    // Aligning on the received count also right-aligns a short (partial) product.
    function automatic logic [2*W-1:0] finalise(input logic [2*W-1:0] acc_v,
                                                input logic [CNT_W-1:0] cnt_v,
                                                input logic [3:0]       bsz,
                                                input logic             sgn);
        logic [2*W-1:0] r;
        logic [2*W-1:0] keep;
        logic [2*W-1:0] top;
        logic           sbit;
        int             width;
        r     = acc_v >> (2*W - int'(cnt_v) * P);
        width = 2 * int'(bsz);
        keep  = ~({(2*W){1'b1}} << width);
        sbit  = 1'b0;
        if (sgn && width != 0) begin
            top  = r >> (width - 1);
            sbit = top[0];
        end
        return (r & keep) | ({(2*W){sbit}} & ~keep);
    endfunction

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        bsz_d    = bsz_q;
        sgn_d    = sgn_q;
        prod_d   = prod_q;
        valid_d  = valid_q;
        short_d  = short_q;
        ovf_d    = ovf_q;
        open_req = 1'b0;

        case (state_q)
            IDLE: begin
                if (newOut) ovf_d = 1'b1;
                if (start)  open_req = 1'b1;
            end
            COLLECT: begin
                if (start) ovf_d = 1'b1;
                if (newOut) begin
                    acc_d = {p, acc_q[2*W-1:P]};
                    cnt_d = cnt_q + 1'b1;
                end
                if (newOut && cnt_d == n_q) begin
                    prod_d  = finalise(acc_d, cnt_d, bsz_q, sgn_q);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (done) begin
                    short_d = 1'b1;
                    prod_d  = finalise(acc_d, cnt_d, bsz_q, sgn_q);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (newOut) ovf_d = 1'b1;
                if (valid_q && prod_ready) begin
                    valid_d  = 1'b0;
                    state_d  = IDLE;
                    open_req = start;
                end else if (start) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Opening a product is shared by IDLE and the HOLD back-to-back handshake.
        if (open_req) begin
            bsz_d = bitSize;
            sgn_d = signed_mode;
            n_d   = n_start;
            acc_d = '0;
            cnt_d = '0;
            if (n_start == '0) begin
                prod_d  = '0;
                valid_d = 1'b1;
                state_d = HOLD;
            end else begin
                state_d = COLLECT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values produced by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            bsz_q   <= '0;
            sgn_q   <= 1'b0;
            prod_q  <= '0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            bsz_q   <= bsz_d;
            sgn_q   <= sgn_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
            short_q <= short_d;
            ovf_q   <= ovf_d;
        end
    end

    assign prod_o     = prod_q;
    assign prod_valid = valid_q;
    assign busy       = (state_q != IDLE);
    assign short_err  = short_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_seq_mult_collector.sv
// Self-checking bench for seq_mult_collector: a behavioural model built from the
// product rules is compared every cycle, plus literal expectations per scenario.
module tb_seq_mult_collector;

    localparam int P = 2;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [3:0]     bitSize;
    logic           signed_mode;
    logic [P-1:0]   p;
    logic           newOut;
    logic           done;
    logic [2*W-1:0] prod_o;
    logic           prod_valid;
    logic           prod_ready;
    logic           busy;
    logic           short_err;
    logic           ovf_err;

    seq_mult_collector #(.P(P), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bitSize     (bitSize),
        .signed_mode (signed_mode),
        .p           (p),
        .newOut      (newOut),
        .done        (done),
        .prod_o      (prod_o),
        .prod_valid  (prod_valid),
        .prod_ready  (prod_ready),
        .busy        (busy),
        .short_err   (short_err),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Behavioural model: phase 0 idle, 1 collecting, 2 holding a result.
    int          m_phase;
    int          m_n;
    int          m_bsz;
    bit          m_sgn;
    int          m_slices[$];
    logic [31:0] m_prod;
    bit          m_valid;
    bit          m_short;
    bit          m_ovf;

    task model_reset();
        m_phase = 0; m_n = 0; m_bsz = 0; m_sgn = 0;
        m_slices.delete();
        m_prod = '0; m_valid = 0; m_short = 0; m_ovf = 0;
    endtask

    task model_open();
        m_bsz = int'(bitSize);
        m_sgn = signed_mode;
        m_n   = (2 * m_bsz + P - 1) / P;
        m_slices.delete();
        if (m_n == 0) begin
            m_prod = '0; m_valid = 1; m_phase = 2;
        end else begin
            m_phase = 1;
        end
    endtask

    task model_finish();
        logic [63:0] v;
        logic [63:0] mask;
        int          bits;
        v = '0;
        foreach (m_slices[i]) v = v | (64'(m_slices[i]) << (i * P));
        bits = 2 * m_bsz;
        mask = (64'd1 << bits) - 64'd1;
        v = v & mask;
        if (m_sgn && bits != 0 && ((v >> (bits - 1)) & 64'd1) == 64'd1) v = v | ~mask;
        m_prod  = v[31:0];
        m_valid = 1;
        m_phase = 2;
    endtask

    task model_tick();
        bit hs;
        hs = m_valid && prod_ready;
        case (m_phase)
            0: begin
                if (newOut) m_ovf = 1;
                if (start) model_open();
            end
            1: begin
                if (start) m_ovf = 1;
                if (newOut) m_slices.push_back(int'(p));
                if (m_slices.size() == m_n) model_finish();
                else if (done) begin m_short = 1; model_finish(); end
            end
            default: begin
                if (newOut) m_ovf = 1;
                if (hs) begin
                    m_valid = 0; m_phase = 0;
                    if (start) model_open();
                end else if (start) m_ovf = 1;
            end
        endcase
    endtask

    always @(posedge clk) if (rst_n === 1'b1) model_tick();

    always @(negedge clk) begin
        check("cmp_prod_valid", 32'(prod_valid), 32'(m_valid));
        check("cmp_busy",       32'(busy),       32'(m_phase != 0));
        check("cmp_short_err",  32'(short_err),  32'(m_short));
        check("cmp_ovf_err",    32'(ovf_err),    32'(m_ovf));
        if (m_valid) check("cmp_prod_o", prod_o, m_prod);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [3:0] bs, input logic sg);
        start = 1'b1; bitSize = bs; signed_mode = sg;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [P-1:0] pv, input logic dn);
        newOut = 1'b1; p = pv; done = dn;
        tick();
        newOut = 1'b0; done = 1'b0;
    endtask

    task automatic accept(input string name);
        int k = 0;
        while (!prod_valid && k < 50) begin tick(); k++; end
        check({name, "_valid_wait"}, 32'(prod_valid), 32'd1);
        prod_ready = 1'b1;
        tick();
        prod_ready = 1'b0;
    endtask

    // Stands in for seq_mult: operands truncated to bs bits, product emitted
    // LSB-first one slice every other cycle, done with the last slice.
    task automatic e2e(input logic [7:0] a, input logic [7:0] b, input logic [3:0] bs, input bit sg);
        longint      sa, sb, pr;
        logic [63:0] raw;
        int          n;
        sa = longint'(a) & ((longint'(1) << bs) - 1);
        sb = longint'(b) & ((longint'(1) << bs) - 1);
        if (sg && ((sa >> (bs - 1)) & 1) == 1) sa = sa - (longint'(1) << bs);
        if (sg && ((sb >> (bs - 1)) & 1) == 1) sb = sb - (longint'(1) << bs);
        pr  = sa * sb;
        raw = 64'(pr);
        n   = (2 * int'(bs) + P - 1) / P;
        do_start(bs, sg);
        for (int i = 0; i < n; i++) begin
            tick();
            send(raw[i*P +: P], i == n - 1);
        end
        check("e2e_valid", 32'(prod_valid), 32'd1);
        check("e2e_prod",  prod_o, raw[31:0]);
        check("e2e_short", 32'(short_err), 32'd0);
        accept("e2e");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; bitSize = '0; signed_mode = 1'b0;
        p = '0; newOut = 1'b0; done = 1'b0; prod_ready = 1'b0;
        model_reset();
        tick(); tick();
        check("reset_prod_o", prod_o, 32'h0);
        check("reset_valid",  32'(prod_valid), 32'd0);
        check("reset_busy",   32'(busy), 32'd0);
        check("reset_errs",   32'({short_err, ovf_err}), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: unsigned 4-bit product 0xA9, valid one cycle after the last slice
        do_start(4'd4, 1'b0);
        send(2'b01, 1'b0); send(2'b10, 1'b0); send(2'b10, 1'b0);
        check("t1_not_yet_valid", 32'(prod_valid), 32'd0);
        send(2'b10, 1'b0);
        check("t1_valid", 32'(prod_valid), 32'd1);
        check("t1_prod",  prod_o, 32'h0000_00A9);
        done = 1'b1; tick(); done = 1'b0;
        check("t1_late_done_ignored", 32'(short_err), 32'd0);
        accept("t1");

        // 2: same slices, signed, consumer stalls for 5 cycles
        do_start(4'd4, 1'b1);
        send(2'b01, 1'b0); send(2'b10, 1'b0); send(2'b10, 1'b0); send(2'b10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t2_prod_stable", prod_o, 32'hFFFF_FFA9);
            tick();
        end
        accept("t2");

        // 3: zero-width product completes immediately
        do_start(4'd0, 1'b1);
        check("t3_valid", 32'(prod_valid), 32'd1);
        check("t3_prod",  prod_o, 32'h0);
        accept("t3");

        // 4: done after two of four slices
        do_start(4'd4, 1'b0);
        send(2'b01, 1'b0); send(2'b10, 1'b0);
        done = 1'b1; tick(); done = 1'b0;
        check("t4_short_err", 32'(short_err), 32'd1);
        check("t4_valid",     32'(prod_valid), 32'd1);
        check("t4_prod",      prod_o, 32'h0000_0009);
        accept("t4");

        // 5: stray slice in IDLE, extra start during COLLECT
        check("t5_ovf_before", 32'(ovf_err), 32'd0);
        send(2'b11, 1'b0);
        check("t5_ovf_idle", 32'(ovf_err), 32'd1);
        do_start(4'd4, 1'b0);
        send(2'b01, 1'b0);
        do_start(4'd2, 1'b1);
        check("t5_busy_kept", 32'(busy), 32'd1);
        send(2'b10, 1'b0); send(2'b10, 1'b0); send(2'b10, 1'b0);
        check("t5_prod", prod_o, 32'h0000_00A9);
        accept("t5");

        // 6: asynchronous reset in the middle of a product
        do_start(4'd4, 1'b1);
        send(2'b01, 1'b0); send(2'b10, 1'b0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("t6_prod_o", prod_o, 32'h0);
        check("t6_busy",   32'(busy), 32'd0);
        check("t6_valid",  32'(prod_valid), 32'd0);
        check("t6_errs",   32'({short_err, ovf_err}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(4'd4, 1'b0);
        send(2'b01, 1'b0); send(2'b10, 1'b0); send(2'b10, 1'b0); send(2'b10, 1'b0);
        check("t6_clean_prod", prod_o, 32'h0000_00A9);

        // 7: next start in the same cycle as the handshake
        prod_ready = 1'b1; start = 1'b1; bitSize = 4'd4; signed_mode = 1'b1;
        tick();
        prod_ready = 1'b0; start = 1'b0;
        check("t7_busy",  32'(busy), 32'd1);
        check("t7_valid", 32'(prod_valid), 32'd0);
        send(2'b01, 1'b0); send(2'b10, 1'b0); send(2'b10, 1'b0); send(2'b10, 1'b0);
        check("t7_prod", prod_o, 32'hFFFF_FFA9);
        check("t7_no_ovf", 32'(ovf_err), 32'd0);
        accept("t7");

        // End-to-end against a seq_mult stand-in and an arithmetic golden product
        e2e(8'h2D, 8'h9D, 4'd4, 1'b0);
        e2e(8'h2D, 8'h9D, 4'd4, 1'b1);
        e2e(8'h2D, 8'h9D, 4'd8, 1'b0);
        e2e(8'h2D, 8'h9D, 4'd8, 1'b1);
        check("end_no_ovf", 32'(ovf_err), 32'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
